// File: rtl/mod_pkg.sv
// Shared types and sizing for the sequential modulo unit.
// No logic of its own; imported by the encoder and the top level.
// No flow control; constants and types only.
package mod_pkg;

    localparam int MOD_WIDTH = 32;
    localparam int IDX_W     = $clog2(MOD_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/mod_msb_enc.sv
// Priority encoder returning the index of the highest set bit of a (0 when a==0).
// Latency: combinational, zero cycles.
// No flow control; output follows input.
module mod_msb_enc
    import mod_pkg::*;
#(
    parameter int WIDTH = MOD_WIDTH,
    parameter int IW    = IDX_W
) (
    input  logic [WIDTH-1:0] a,
    output logic [IW-1:0]    idx
);

    // Ascending scan: the last set bit seen wins, which is the MSB.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mod_unit.sv
// Sequential unsigned remainder A % B, radix-2 restoring, starting at the MSB of A.
// Latency: We rises after edge k+idx+2 (idx = MSB index of A); divide-by-zero after k+1.
// No backpressure: En is sampled only in IDLE and ignored while busy.
module mod_unit
    import mod_pkg::*;
#(
    parameter int WIDTH = MOD_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Mod_Result,
    output logic             We
);

    localparam int IW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rem_q;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    msb_idx;
    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic [WIDTH-1:0] rem_nxt;

    mod_msb_enc #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_msb_enc (
        .a   (A),
        .idx (msb_idx)
    );

    // The shifted remainder needs one extra bit; the difference always fits
    // in WIDTH bits because the true result is below b_q.
    always_comb begin
        trial    = {rem_q, a_q[idx_q]};
        trial_ge = (trial >= {1'b0, b_q});
        rem_nxt  = trial_ge ? (trial[WIDTH-1:0] - b_q) : trial[WIDTH-1:0];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (En) begin
                    state_nxt = (B == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (idx_q == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            Mod_Result <= '0;
            We         <= 1'b0;
        end else begin
            We <= 1'b0;
            case (state)
                IDLE: begin
                    if (En) begin
                        a_q   <= A;
                        b_q   <= B;
                        idx_q <= msb_idx;
                        // Divide by zero skips RUN and reports the dividend.
                        rem_q <= (B == '0) ? A : '0;
                    end
                end
                RUN: begin
                    rem_q <= rem_nxt;
                    if (idx_q != '0) begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                DONE: begin
                    Mod_Result <= rem_q;
                    We         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_unit.sv
`timescale 1ns/1ps
module tb_mod_unit;

    logic        Clk;
    logic        Reset;
    logic        En;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Mod_Result;
    logic        We;

    int nvec;
    int nerr;

    mod_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .En         (En),
        .A          (A),
        .B          (B),
        .Mod_Result (Mod_Result),
        .We         (We)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: bit length of a by repeated halving; one RUN edge per bit.
    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
        longint unsigned v;
        int bits;
        if (b == 0) return 1;
        v = a;
        bits = 0;
        while (v != 0) begin
            v = v >> 1;
            bits++;
        end
        return ((bits == 0) ? 0 : bits - 1) + 2;
    endfunction

    function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    // Start at edge k, then count edges until We; check value and one-cycle pulse.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string tag);
        int seen;
        A  = a;
        B  = b;
        En = 1'b1;
        @(posedge Clk); #1;
        En = 1'b0;
        A  = $urandom;
        B  = $urandom;
        seen = 0;
        for (int e = 1; e <= 60 && seen == 0; e++) begin
            @(posedge Clk); #1;
            if (We) seen = e;
        end
        chk({tag, " latency"}, 64'(seen), 64'(exp_lat));
        chk({tag, " result"}, {32'b0, Mod_Result}, {32'b0, exp_res});
        @(posedge Clk); #1;
        chk({tag, " we_drop"}, {63'b0, We}, 64'd0);
        chk({tag, " hold"}, {32'b0, Mod_Result}, {32'b0, exp_res});
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int we_cnt;
        int pulses;
        int pcyc[3];
        logic [31:0] pres[3];
        logic [31:0] ra, rb;
        int l100, l50;

        nvec = 0;
        nerr = 0;

        tbl[0] = '{32'd16,         32'd5,          32'd1,    6};
        tbl[1] = '{32'hFFFF_FFFF,  32'd7,          32'd3,    33};
        tbl[2] = '{32'h8000_0000,  32'h8000_0000,  32'd0,    33};
        tbl[3] = '{32'd3,          32'd10,         32'd3,    3};
        tbl[4] = '{32'd0,          32'd9,          32'd0,    2};
        tbl[5] = '{32'd1234,       32'd0,          32'd1234, 1};
        tbl[6] = '{32'd100,        32'd7,          32'd2,    8};
        tbl[7] = '{32'd50,         32'd7,          32'd1,    7};
        tbl[8] = '{32'd1,          32'd1,          32'd0,    2};

        // Reset state, and silence with En low.
        Reset = 1'b0;
        En    = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        chk("reset result", {32'b0, Mod_Result}, 64'd0);
        chk("reset we", {63'b0, We}, 64'd0);
        we_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            if (We) we_cnt++;
        end
        chk("idle we count", 64'(we_cnt), 64'd0);

        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, $sformatf("tbl%0d", i));
        end

        // En held high: back-to-back ops, operand change mid-run of the second.
        l100 = model_lat(32'd100, 32'd7);
        l50  = model_lat(32'd50, 32'd7);
        A  = 32'd100;
        B  = 32'd7;
        En = 1'b1;
        pulses = 0;
        for (int cyc = 1; cyc <= 100 && pulses < 3; cyc++) begin
            @(posedge Clk); #1;
            if (pulses == 1 && cyc == pcyc[0] + 3) A = 32'd50;
            if (We) begin
                pcyc[pulses] = cyc;
                pres[pulses] = Mod_Result;
                pulses++;
                if (pulses == 3) En = 1'b0;
            end
        end
        chk("held pulses", 64'(pulses), 64'd3);
        chk("held p1 time", 64'(pcyc[0]), 64'(1 + l100));
        chk("held p2 time", 64'(pcyc[1]), 64'(pcyc[0] + 1 + l100));
        chk("held p3 time", 64'(pcyc[2]), 64'(pcyc[1] + 1 + l50));
        chk("held r1", {32'b0, pres[0]}, {32'b0, model_res(32'd100, 32'd7)});
        chk("held r2", {32'b0, pres[1]}, {32'b0, model_res(32'd100, 32'd7)});
        chk("held r3", {32'b0, pres[2]}, {32'b0, model_res(32'd50, 32'd7)});
        we_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge Clk); #1;
            if (We) we_cnt++;
        end
        chk("held stop we count", 64'(we_cnt), 64'd0);

        // Reset mid-run aborts without a write.
        A  = 32'hFFFF_0000;
        B  = 32'd3;
        En = 1'b1;
        @(posedge Clk); #1;
        En = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk); #1;
        end
        Reset = 1'b0;
        #1;
        chk("abort result", {32'b0, Mod_Result}, 64'd0);
        chk("abort we", {63'b0, We}, 64'd0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        we_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (We) we_cnt++;
        end
        chk("abort we count", 64'(we_cnt), 64'd0);
        run_op(32'd16, 32'd5, 32'd1, 6, "post_abort");

        // Random scoreboard with forced divisor corner cases.
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 6))
                0: rb = 32'd1;
                1: rb = ra;
                2: rb = 32'd0;
                3: begin
                    ra = ra >> $urandom_range(0, 31);
                    rb = rb >> $urandom_range(0, 31);
                end
                4: rb = rb >> $urandom_range(16, 31);
                default: ;
            endcase
            run_op(ra, rb, model_res(ra, rb), model_lat(ra, rb), $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
